// File: rtl/cve2_hpm_unit_pkg.sv
// rtl/cve2_hpm_unit_pkg.sv - HPM CSR addresses, select enum and address decode helpers
package cve2_hpm_unit_pkg;

  localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB03;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB83;
  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h323;
  localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;

  localparam int CSR_MHPMEVENT_OF_BIT = 31;
  localparam int CSR_HPM_FIRST_IDX    = 3;

  typedef enum logic [2:0] {
    HPM_SEL_NONE,
    HPM_SEL_CNT_LO,
    HPM_SEL_CNT_HI,
    HPM_SEL_EVENT,
    HPM_SEL_INHIBIT
  } hpm_csr_sel_e;

  // Each HPM range is a 32-entry CSR block whose first three slots belong to the fixed counters.
  function automatic hpm_csr_sel_e hpm_decode_sel(input logic [11:0] addr);
    hpm_csr_sel_e sel;
    sel = HPM_SEL_NONE;
    if (addr == CSR_MCOUNTINHIBIT) begin
      sel = HPM_SEL_INHIBIT;
    end else if (addr[4:0] >= 5'(CSR_HPM_FIRST_IDX)) begin
      if (addr[11:5] == CSR_OFF_MHPMCOUNTER[11:5]) begin
        sel = HPM_SEL_CNT_LO;
      end else if (addr[11:5] == CSR_OFF_MHPMCOUNTERH[11:5]) begin
        sel = HPM_SEL_CNT_HI;
      end else if (addr[11:5] == CSR_OFF_MHPMEVENT[11:5]) begin
        sel = HPM_SEL_EVENT;
      end
    end
    return sel;
  endfunction

  function automatic logic [4:0] hpm_decode_idx(input logic [11:0] addr);
    return addr[4:0] - 5'(CSR_HPM_FIRST_IDX);
  endfunction

endpackage

// File: rtl/cve2_hpm_counter.sv
// rtl/cve2_hpm_counter.sv - one HPM counter with event select, write priority and overflow flag (CVE2_HPM_OVERFLOW_IRQ_EN)
module cve2_hpm_counter
  import cve2_hpm_unit_pkg::*;
#(
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumEvents-1:0]    events_i,
  input  logic                    stop_i,
  input  logic                    inh_i,
  input  logic                    we_lo_i,
  input  logic                    we_hi_i,
  input  logic                    we_ev_i,
  input  logic [31:0]             wdata_i,
  output logic [CounterWidth-1:0] cnt_o,
  output logic [NumEvents-1:0]    evsel_o,
  output logic                    of_o
);

  logic [CounterWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NumEvents-1:0]    evsel_q;
  logic                    en;

  // evsel_q and inh_i are the pre-write values, so a same-cycle write never affects this increment.
  assign en      = (|(events_i & evsel_q)) & ~inh_i & ~stop_i;
  assign cnt_inc = cnt_q + CounterWidth'(1);

  // Each half independently takes software data over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (en) begin
      cnt_d[31:0] = cnt_inc[31:0];
    end
    if (we_hi_i) begin
      cnt_d[CounterWidth-1:32] = wdata_i[CounterWidth-33:0];
    end else if (en) begin
      cnt_d[CounterWidth-1:32] = cnt_inc[CounterWidth-1:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      evsel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (we_ev_i) begin
        evsel_q <= wdata_i[NumEvents-1:0];
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign evsel_o = evsel_q;

`ifdef CVE2_HPM_OVERFLOW_IRQ_EN
  logic of_q;
  logic wrap;

  assign wrap = en & (&cnt_q) & ~we_lo_i & ~we_hi_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      of_q <= 1'b0;
    end else if (we_ev_i) begin
      of_q <= wdata_i[CSR_MHPMEVENT_OF_BIT];
    end else if (wrap) begin
      of_q <= 1'b1;
    end
  end

  assign of_o = of_q;
`else
  assign of_o = 1'b0;
`endif

endmodule

// File: rtl/cve2_hpm_unit.sv
// rtl/cve2_hpm_unit.sv - HPM unit top: CSR decode, mcountinhibit, read mux, overflow irq (CVE2_HPM_OVERFLOW_IRQ_EN)
module cve2_hpm_unit
  import cve2_hpm_unit_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 csr_access_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 debug_mode_i,
`ifdef CVE2_HPM_OVERFLOW_IRQ_EN
  input  logic                 dcsr_stopcount_i,
  output logic                 irq_ovf_o
`else
  input  logic                 dcsr_stopcount_i
`endif
);

  hpm_csr_sel_e           sel;
  logic [4:0]             idx;
  logic                   csr_we;
  logic                   stop;
  logic [NumCounters-1:0] inh_q;
  logic [NumCounters-1:0] of;

  logic [CounterWidth-1:0] cnt   [NumCounters];
  logic [NumEvents-1:0]    evsel [NumCounters];

  assign sel       = hpm_decode_sel(csr_addr_i);
  assign idx       = hpm_decode_idx(csr_addr_i);
  assign csr_we    = csr_access_i & csr_we_i;
  assign stop      = debug_mode_i & dcsr_stopcount_i;
  assign csr_hit_o = (sel != HPM_SEL_NONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inh_q <= '0;
    end else if (csr_we && sel == HPM_SEL_INHIBIT) begin
      inh_q <= csr_wdata_i[NumCounters+2:3];
    end
  end

  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    logic hit_k;
    assign hit_k = csr_we & (idx == 5'(k));

    cve2_hpm_counter #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents)
    ) u_counter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .events_i (events_i),
      .stop_i   (stop),
      .inh_i    (inh_q[k]),
      .we_lo_i  (hit_k & (sel == HPM_SEL_CNT_LO)),
      .we_hi_i  (hit_k & (sel == HPM_SEL_CNT_HI)),
      .we_ev_i  (hit_k & (sel == HPM_SEL_EVENT)),
      .wdata_i  (csr_wdata_i),
      .cnt_o    (cnt[k]),
      .evsel_o  (evsel[k]),
      .of_o     (of[k])
    );
  end

  // Unimplemented indices never match a counter and fall through to zero.
  always_comb begin
    csr_rdata_o = '0;
    if (sel == HPM_SEL_INHIBIT) begin
      csr_rdata_o[NumCounters+2:3] = inh_q;
    end
    for (int k = 0; k < NumCounters; k++) begin
      if (idx == 5'(k)) begin
        case (sel)
          HPM_SEL_CNT_LO: csr_rdata_o = cnt[k][31:0];
          HPM_SEL_CNT_HI: csr_rdata_o = 32'(cnt[k][CounterWidth-1:32]);
          HPM_SEL_EVENT: begin
            csr_rdata_o[NumEvents-1:0]          = evsel[k];
            csr_rdata_o[CSR_MHPMEVENT_OF_BIT]   = of[k];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CVE2_HPM_OVERFLOW_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_ovf_o <= 1'b0;
    end else begin
      irq_ovf_o <= |(of & ~inh_q);
    end
  end
`endif

endmodule
